// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
// Imported by the fetch unit, its queue and its memory interface.
package if_fetch_unit_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam logic [PC_W-1:0]    RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int                 DEPTH_DEFAULT    = 2;
  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Fetches are word-granular; stray low bits of a target are simply cleared.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response port: req/ready handshake for
// addresses, rvalid strobe for in-order returned words.
interface if_fetch_unit_if;
  import if_fetch_unit_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ready;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );

endinterface

// File: rtl/if_fetch_unit_fifo.sv
// Small synchronous FIFO with flush and same-cycle push/pop; head is
// presented combinationally. Used for both the fetch queue and the pc-tag queue.
module if_fetch_unit_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];
  // A full queue may still accept a push when the head leaves in the same cycle.
  assign do_push   = push && (!full || pop);
  assign do_pop    = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; count alone decides what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS IF stage: owns the fetch PC, issues credit-limited word requests,
// queues returned words with their PCs and presents one per cycle to IF/ID.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = DEPTH_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  if_fetch_unit_if.master    imem_bus,
  output logic [PC_W-1:0]    IF_pc,
  output logic [INSTR_W-1:0] IF_instruction,
  output logic               IF_valid
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PC_W-1:0]  fetch_pc;
  logic [CNT_W-1:0] outstanding, outstanding_next, drop_cnt;
  logic [CNT_W-1:0] occupancy, tag_count;
  logic             fetch_full, fetch_empty, fetch_push, pop_head;
  logic             tag_full, tag_empty;
  logic             credit, accept, resp;
  logic [PC_W-1:0]  tag_pc;
  fetch_entry_t     head_entry, push_entry;

  // Queued words plus words in flight never exceed the queue depth.
  assign credit = (int'(occupancy) + int'(outstanding)) < DEPTH;

  assign imem_bus.imem_req  = !reset && !redirect && credit;
  assign imem_bus.imem_addr = fetch_pc;
  assign accept             = imem_bus.imem_req && imem_bus.imem_ready;
  assign resp               = imem_bus.imem_rvalid && !tag_empty;

  assign outstanding_next = outstanding + CNT_W'(accept) - CNT_W'(resp);

  // Words belonging to a squashed fetch stream never reach the queue.
  assign fetch_push = resp && (drop_cnt == '0) && !redirect;
  assign push_entry = '{pc: tag_pc, instr: imem_bus.imem_rdata};
  assign pop_head   = IF_valid && !stall;

  if_fetch_unit_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_fetch_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect),
    .push      (fetch_push),
    .push_data (push_entry),
    .pop       (pop_head),
    .head_data (head_entry),
    .full      (fetch_full),
    .empty     (fetch_empty),
    .count     (occupancy)
  );

  // Tags survive a redirect so late responses still pair with their request.
  if_fetch_unit_fifo #(.DEPTH(DEPTH), .WIDTH(PC_W)) u_tag_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (1'b0),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (resp),
    .head_data (tag_pc),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect) begin
        fetch_pc <= word_align(redirect_pc);
        drop_cnt <= outstanding_next;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (resp && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_W'(1);
      end
    end
  end

  // NOTE: defaults first so no path through always_comb can infer a latch.
  always_comb begin
    IF_valid       = !fetch_empty;
    IF_pc          = '0;
    IF_instruction = NOP_INSTR;
    if (IF_valid) begin
      IF_pc          = head_entry.pc;
      IF_instruction = head_entry.instr;
    end
  end

  a_no_orphan_rvalid: assert property (@(posedge clock) disable iff (reset)
    imem_bus.imem_rvalid |-> !tag_empty);
  a_fetch_no_overflow: assert property (@(posedge clock) disable iff (reset)
    fetch_push |-> (!fetch_full || pop_head));
  a_tag_no_overflow: assert property (@(posedge clock) disable iff (reset)
    accept |-> !tag_full);
  a_tag_tracks_outstanding: assert property (@(posedge clock) disable iff (reset)
    tag_count == outstanding);

endmodule
